sha_mem_responder: RTL and testbench

Word-addressed memory responder serving the SHA-256 core's memory bus: answers the core's reads with one-cycle registered latency and absorbs its digest writes. A host port preloads messages and dumps results while the core is idle. A capture FSM assembles the eight written hash words into a 256-bit digest with a valid flag. Sits between the testbench or host logic and the hash core, replacing the behavioural memory model.

---
 rtl/sha_pkg.sv | 22 ++
 rtl/sha_digest_capture.sv | 103 ++++++++++
 rtl/sha_mem_responder.sv | 104 ++++++++++
 tb/tb_sha_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 memory responder and its digest capture.
package sha_pkg;

  typedef logic [31:0] word_t;

  localparam int DIGEST_WORDS = 8;
  localparam int IDX_W        = $clog2(DIGEST_WORDS);

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RUN  = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
    if (en && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/sha_digest_capture.sv
// Watches core writes and assembles the eight sequential hash words at cap_base
// into a held 256-bit digest.
//
// state    | meaning
// CAP_IDLE | waiting for a write to cap_base (word 0)
// CAP_RUN  | expecting a write to cap_base+idx
// CAP_DONE | all eight words captured, digest held until ack or restart
module sha_digest_capture
  import sha_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         restart,
  input  logic         wr_en,
  input  logic [15:0]  wr_addr,
  input  word_t        wr_data,
  input  logic [15:0]  cap_base,
  input  logic         digest_ack,
  output logic         digest_valid,
  output logic [255:0] digest
);

  cap_state_e        state, state_nxt, st_eff;
  logic [IDX_W-1:0]  idx, idx_nxt, slot;
  logic              store;
  logic [15:0]       expect_addr;
  word_t             words [DIGEST_WORDS];

  assign expect_addr = cap_base + 16'(idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CAP_IDLE;
      idx   <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) begin
        words[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (store) begin
        words[slot] <= wr_data;
      end
    end
  end

  // A restart is handled as if the FSM were already idle, so a word-0 write
  // in the same cycle still starts a new capture.
  always_comb begin
    st_eff    = restart ? CAP_IDLE : state;
    state_nxt = st_eff;
    idx_nxt   = restart ? '0 : idx;
    store     = 1'b0;
    slot      = '0;
    case (st_eff)
      CAP_IDLE: begin
        if (wr_en && (wr_addr == cap_base)) begin
          store     = 1'b1;
          idx_nxt   = IDX_W'(1);
          state_nxt = CAP_RUN;
        end
      end
      CAP_RUN: begin
        if (wr_en) begin
          if (wr_addr == expect_addr) begin
            store = 1'b1;
            slot  = idx;
            if (idx == IDX_W'(DIGEST_WORDS - 1)) begin
              idx_nxt   = '0;
              state_nxt = CAP_DONE;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else if (wr_addr == cap_base) begin
            store   = 1'b1;
            idx_nxt = IDX_W'(1);
          end else begin
            idx_nxt   = '0;
            state_nxt = CAP_IDLE;
          end
        end
      end
      CAP_DONE: begin
        if (digest_ack) begin
          state_nxt = CAP_IDLE;
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = CAP_IDLE;
      end
    endcase
  end

  always_comb begin
    digest_valid = (state == CAP_DONE);
    digest       = '0;
    for (int i = 0; i < DIGEST_WORDS; i++) begin
      digest[255 - 32*i -: 32] = words[i];
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// Word-addressed memory serving the SHA-256 core's bus with a host side port for
// preload/dump, access counters and digest capture.
module sha_mem_responder
  import sha_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         core_busy,
  input  logic         mem_we,
  input  logic [15:0]  mem_addr,
  input  word_t        mem_write_data,
  output word_t        mem_read_data,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic         host_we,
  input  logic [15:0]  host_addr,
  input  word_t        host_wdata,
  output logic         host_rvalid,
  output word_t        host_rdata,
  input  logic [15:0]  cap_base,
  output logic         digest_valid,
  output logic [255:0] digest,
  input  logic         digest_ack,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic         addr_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  word_t          mem [DEPTH];
  logic           host_acc, host_rd, core_rd, core_wr;
  logic           port_we, in_range, busy_q, busy_rise;
  logic [15:0]    port_addr, rd_base, wr_base;
  logic [AW-1:0]  port_idx;
  word_t          port_wdata, port_rdata;

  // One shared array port: the core owns it outright while busy.
  assign host_ready = !core_busy;
  assign host_acc   = host_valid && !core_busy;
  assign host_rd    = host_acc && !host_we;
  assign core_rd    = core_busy && !mem_we;
  assign core_wr    = core_busy && mem_we;
  assign port_addr  = core_busy ? mem_addr : host_addr;
  assign port_wdata = core_busy ? mem_write_data : host_wdata;
  assign in_range   = {1'b0, port_addr} < DEPTH_L;
  assign port_idx   = port_addr[AW-1:0];
  assign port_we    = in_range && (core_wr || (host_acc && host_we));
  assign port_rdata = in_range ? mem[port_idx] : '0;

  assign busy_rise  = core_busy && !busy_q;
  assign rd_base    = busy_rise ? '0 : rd_count;
  assign wr_base    = busy_rise ? '0 : wr_count;

  // Contents deliberately survive reset so a host can dump after a core abort.
  always_ff @(posedge clk) begin
    if (port_we) begin
      mem[port_idx] <= port_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q        <= 1'b0;
      mem_read_data <= '0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
      rd_count      <= '0;
      wr_count      <= '0;
      addr_err      <= 1'b0;
    end else begin
      busy_q      <= core_busy;
      host_rvalid <= host_rd;
      if (core_busy) begin
        mem_read_data <= port_rdata;
      end
      if (host_rd) begin
        host_rdata <= port_rdata;
      end
      if ((core_busy || host_acc) && !in_range) begin
        addr_err <= 1'b1;
      end
      rd_count <= sat_inc16(rd_base, core_rd);
      wr_count <= sat_inc16(wr_base, core_wr);
    end
  end

  sha_digest_capture u_cap (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      (busy_rise),
    .wr_en        (core_wr),
    .wr_addr      (mem_addr),
    .wr_data      (mem_write_data),
    .cap_base     (cap_base),
    .digest_ack   (digest_ack),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder with a queue of expected read/digest results.
module tb_sha_mem_responder;
  import sha_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         core_busy = 1'b0;
  logic         mem_we = 1'b0;
  logic [15:0]  mem_addr = '0;
  word_t        mem_write_data = '0;
  word_t        mem_read_data;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic         host_we = 1'b0;
  logic [15:0]  host_addr = '0;
  word_t        host_wdata = '0;
  logic         host_rvalid;
  word_t        host_rdata;
  logic [15:0]  cap_base = 16'h0040;
  logic         digest_valid;
  logic [255:0] digest;
  logic         digest_ack = 1'b0;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic         addr_err;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q [$];
  logic [255:0] e;

  always #5 clk = ~clk;

  sha_mem_responder #(.DEPTH(1024)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_busy      (core_busy),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .cap_base       (cap_base),
    .digest_valid   (digest_valid),
    .digest         (digest),
    .digest_ack     (digest_ack),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .addr_err       (addr_err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input word_t d);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_valid = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input string tag, input logic [15:0] a, input word_t expv);
    exp_q.push_back(256'(expv));
    host_valid = 1'b1; host_we = 1'b0; host_addr = a;
    step();
    host_valid = 1'b0;
    chk({tag, "_rvalid"}, 256'(host_rvalid), 256'(1'b1));
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, 256'(host_rdata), e);
    step();
    chk({tag, "_rvalid_pulse"}, 256'(host_rvalid), 256'(1'b0));
  endtask

  task automatic core_wr(input logic [15:0] a, input word_t d);
    mem_we = 1'b1; mem_addr = a; mem_write_data = d;
    step();
    mem_we = 1'b0;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    step();
    chk("rst_mem_read_data", 256'(mem_read_data), 256'(0));
    chk("rst_digest_valid", 256'(digest_valid), 256'(0));
    chk("rst_digest", digest, 256'(0));
    chk("rst_addr_err", 256'(addr_err), 256'(0));
    reset_n = 1'b1;
    step();

    // host preload and readback
    chk("host_ready_idle", 256'(host_ready), 256'(1'b1));
    host_wr(16'd5, 32'hDEADBEEF);
    host_rd("host5", 16'd5, 32'hDEADBEEF);
    chk("core_rd_untouched", 256'(mem_read_data), 256'(0));

    // core sequential read
    for (int i = 0; i < 20; i++) host_wr(16'(i), 32'(i + 1));
    core_busy = 1'b1; mem_we = 1'b0; mem_addr = 16'd0;
    exp_q.push_back(256'(1));
    for (int i = 1; i <= 20; i++) begin
      step();
      e = exp_q.pop_front();
      chk("core_seq_rd", 256'(mem_read_data), e);
      if (i < 20) begin
        mem_addr = 16'(i);
        exp_q.push_back(256'(i + 1));
      end
    end
    chk("rd_count_20", 256'(rd_count), 256'(20));
    core_busy = 1'b0;
    step();

    // digest capture
    core_busy = 1'b1;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      e = {e[223:0], 32'(32'h11111111 * (k + 1))};
      if (k == 7) exp_q.push_back(e);
      core_wr(16'h0040 + 16'(k), 32'(32'h11111111 * (k + 1)));
      if (k == 6) chk("valid_before_8th", 256'(digest_valid), 256'(0));
    end
    chk("digest_valid", 256'(digest_valid), 256'(1'b1));
    chk("digest_h0", 256'(digest[255:224]), 256'(32'h11111111));
    chk("digest_h7", 256'(digest[31:0]), 256'(32'h88888888));
    e = exp_q.pop_front();
    chk("digest_full", digest, e);
    chk("wr_count_8", 256'(wr_count), 256'(8));
    chk("rd_count_0", 256'(rd_count), 256'(0));

    // ack beats a simultaneous word-0 write
    digest_ack = 1'b1; mem_we = 1'b1; mem_addr = 16'h0040; mem_write_data = 32'h99;
    step();
    digest_ack = 1'b0; mem_we = 1'b0;
    chk("ack_clears_valid", 256'(digest_valid), 256'(0));
    chk("ack_state_idle", 256'(dut.u_cap.state), 256'(CAP_IDLE));
    core_wr(16'h0041, 32'h1234);
    chk("ack_write_not_captured", 256'(dut.u_cap.state), 256'(CAP_IDLE));

    // read-before-write, then read back
    core_wr(16'd3, 32'hCAFE0003);
    chk("read_before_write", 256'(mem_read_data), 256'(32'd4));
    mem_addr = 16'd3;
    exp_q.push_back(256'(32'hCAFE0003));
    step();
    e = exp_q.pop_front();
    chk("core_rd_after_wr", 256'(mem_read_data), e);

    // capture abort then fresh sequence
    core_wr(16'h0040, 32'h1);
    core_wr(16'h0041, 32'h2);
    chk("abort_run", 256'(dut.u_cap.state), 256'(CAP_RUN));
    core_wr(16'h0050, 32'h3);
    chk("abort_idle", 256'(dut.u_cap.state), 256'(CAP_IDLE));
    chk("abort_valid", 256'(digest_valid), 256'(0));
    e = '0;
    for (int k = 0; k < 8; k++) begin
      e = {e[223:0], 32'hA0000000 + 32'(k)};
      core_wr(16'h0040 + 16'(k), 32'hA0000000 + 32'(k));
    end
    exp_q.push_back(e);
    chk("fresh_valid", 256'(digest_valid), 256'(1'b1));
    e = exp_q.pop_front();
    chk("fresh_digest", digest, e);

    // arbitration and range
    mem_addr = 16'd0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'd7; host_wdata = 32'h00000BAD;
    #1;
    chk("host_ready_busy", 256'(host_ready), 256'(0));
    step();
    host_valid = 1'b0; host_we = 1'b0;
    chk("no_host_rvalid_busy", 256'(host_rvalid), 256'(0));
    chk("addr_err_clear", 256'(addr_err), 256'(0));
    mem_addr = 16'h0400;
    step();
    chk("oor_read_zero", 256'(mem_read_data), 256'(0));
    chk("oor_addr_err", 256'(addr_err), 256'(1'b1));
    mem_addr = 16'd0;
    core_busy = 1'b0;
    step();
    chk("done_held_idle", 256'(digest_valid), 256'(1'b1));
    host_rd("host7_blocked", 16'd7, 32'd8);

    // busy rise clears capture and counters
    core_busy = 1'b1; mem_we = 1'b0; mem_addr = 16'd0;
    step();
    chk("rise_valid_clear", 256'(digest_valid), 256'(0));
    chk("rise_rd_count", 256'(rd_count), 256'(1));
    chk("rise_wr_count", 256'(wr_count), 256'(0));

    // async reset mid-capture
    for (int k = 0; k < 3; k++) core_wr(16'h0040 + 16'(k), 32'h55000000 + 32'(k));
    chk("mid_state_run", 256'(dut.u_cap.state), 256'(CAP_RUN));
    chk("mid_wr_count", 256'(wr_count), 256'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_read_data", 256'(mem_read_data), 256'(0));
    chk("arst_host_rdata", 256'(host_rdata), 256'(0));
    chk("arst_host_rvalid", 256'(host_rvalid), 256'(0));
    chk("arst_digest", digest, 256'(0));
    chk("arst_digest_valid", 256'(digest_valid), 256'(0));
    chk("arst_rd_count", 256'(rd_count), 256'(0));
    chk("arst_wr_count", 256'(wr_count), 256'(0));
    chk("arst_addr_err", 256'(addr_err), 256'(0));
    chk("arst_state", 256'(dut.u_cap.state), 256'(CAP_IDLE));
    core_busy = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    host_rd("keep5", 16'd5, 32'd6);
    host_rd("keep19", 16'd19, 32'd20);
    host_rd("keep42", 16'h0042, 32'h55000002);
    host_rd("host_oor", 16'h0800, 32'd0);
    chk("host_oor_addr_err", 256'(addr_err), 256'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
